rr_onehot_arbiter: RTL and testbench

Round-robin request arbiter that sits directly upstream of the 8-to-3 non-priority encoder. It latches up to eight single-cycle request pulses and issues exactly one granted requester at a time as a strictly one-hot 8-bit word. It never presents a multi-hot word, so the non-priority encoder downstream always sees a legal input. Grants are handed off with a valid/ready handshake, and fairness is rotating.

---
 rtl/rr_onehot_arbiter_pkg.sv | 13 +
 rtl/rr_onehot_arbiter_if.sv | 21 ++
 rtl/rr_onehot_arbiter_pick.sv | 28 ++
 rtl/rr_onehot_arbiter.sv | 112 +++++++++++
 tb/tb_rr_onehot_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared constants and types for the round-robin one-hot arbiter.
package rr_arb_pkg;
    localparam int N     = 8;
    localparam int PTR_W = 3;

    typedef logic [N-1:0]     req_vec_t;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between arbiter (master) and its requesters/consumer (slave).
// The ovf signal exists only when RR_OVF_FLAG_EN is defined.
interface rr_onehot_arbiter_if;
    import rr_arb_pkg::*;

    logic     en;
    req_vec_t req;
    req_vec_t grant;
    logic     grant_vld;
    logic     grant_rdy;
    req_vec_t pending;
`ifdef RR_OVF_FLAG_EN
    logic     ovf;

    modport master (input en, req, grant_rdy, output grant, grant_vld, pending, ovf);
    modport slave  (output en, req, grant_rdy, input grant, grant_vld, pending, ovf);
`else
    modport master (input en, req, grant_rdy, output grant, grant_vld, pending);
    modport slave  (output en, req, grant_rdy, input grant, grant_vld, pending);
`endif
endinterface

// File: rtl/rr_onehot_arbiter_pick.sv
// Rotating find-first-set over the pending vector starting at i_ptr; purely combinational.
// No state and no backpressure; o_onehot is zero when o_any is low.
module rr_pick
    import rr_arb_pkg::*;
(
    input  req_vec_t i_pend,
    input  ptr_t     i_ptr,
    output req_vec_t o_onehot,
    output ptr_t     o_idx,
    output logic     o_any
);
    always_comb begin
        ptr_t v_idx;
        v_idx    = '0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        // Index arithmetic wraps in 3 bits, giving Ptr..7 then 0..Ptr-1.
        for (int k = 0; k < N; k++) begin
            v_idx = i_ptr + ptr_t'(k);
            if (!o_any && i_pend[v_idx]) begin
                o_any           = 1'b1;
                o_idx           = v_idx;
                o_onehot[v_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter issuing registered one-hot grants; first grant one edge after Pending sets, then one per cycle.
// Grant holds while grant_rdy is low; optional sticky overflow flag under RR_OVF_FLAG_EN.
module rr_onehot_arbiter
    import rr_arb_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    rr_onehot_arbiter_if.master  io_bus
);
    arb_state_t r_state, w_state_nxt;
    req_vec_t   r_grant, w_grant_nxt;
    req_vec_t   r_pending;
    ptr_t       r_ptr, w_ptr_nxt;
    ptr_t       r_gidx, w_gidx_nxt;

    logic       w_fire;
    req_vec_t   w_acc;
    req_vec_t   w_pend_rem;
    ptr_t       w_gidx_inc;
    ptr_t       w_pick_ptr;
    req_vec_t   w_pick_oh;
    ptr_t       w_pick_idx;
    logic       w_pick_any;

    assign w_fire     = (r_state == BUSY) && io_bus.grant_rdy;
    assign w_acc      = w_fire ? r_grant : '0;
    assign w_pend_rem = r_pending & ~w_acc;
    assign w_gidx_inc = r_gidx + ptr_t'(1);
    // On acceptance the follow-on grant is searched with the already-advanced pointer.
    assign w_pick_ptr = w_fire ? w_gidx_inc : r_ptr;

    rr_pick u_pick (
        .i_pend   (w_pend_rem),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (io_bus.en && w_pick_any) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick_oh;
                    w_gidx_nxt  = w_pick_idx;
                end
            end
            BUSY: begin
                if (w_fire) begin
                    w_ptr_nxt = w_gidx_inc;
                    if (io_bus.en && w_pick_any) begin
                        w_grant_nxt = w_pick_oh;
                        w_gidx_nxt  = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant   <= '0;
            r_gidx    <= '0;
            r_ptr     <= '0;
            r_pending <= '0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_gidx    <= w_gidx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_pending <= w_pend_rem | io_bus.req;
        end
    end

    assign io_bus.grant     = r_grant;
    assign io_bus.grant_vld = (r_state == BUSY);
    assign io_bus.pending   = r_pending;

`ifdef RR_OVF_FLAG_EN
    logic r_ovf;

    // A request merging into a still-pending, unaccepted bit is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (|(io_bus.req & w_pend_rem)) begin
            r_ovf <= 1'b1;
        end
    end

    assign io_bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: vector table plus hand sequences, grant scoreboard.
module tb_rr_onehot_arbiter;
    import rr_arb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_onehot_arbiter_if u_if ();

    rr_onehot_arbiter dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (u_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q[$];
    logic [7:0] mon_exp;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        rdy;
        logic [7:0]  req;
        logic [31:0] sb;
        logic [7:0]  exp_grant;
        logic        exp_vld;
        logic [7:0]  exp_pend;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic r, input logic e, input logic y, input logic [7:0] rq,
                                input logic [31:0] sb, input logic [7:0] g, input logic v,
                                input logic [7:0] p);
        vec_t t;
        t.rst_n = r; t.en = e; t.rdy = y; t.req = rq; t.sb = sb;
        t.exp_grant = g; t.exp_vld = v; t.exp_pend = p;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        u_if.req = '0;
        u_if.en = 1'b0;
        u_if.grant_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Every accepted grant must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && u_if.grant_vld && u_if.grant_rdy) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got grant 0x%0h, expected none", u_if.grant);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("sb_grant", 32'(u_if.grant), 32'(mon_exp));
            end
        end
    end

    initial begin
        logic [7:0] ev;

        vecs[0] = mk(1'b1, 1'b1, 1'b1, 8'h04, 32'h0000_0004, 8'h00, 1'b0, 8'h04);
        vecs[1] = mk(1'b1, 1'b1, 1'b1, 8'h00, 32'h0,         8'h04, 1'b1, 8'h04);
        vecs[2] = mk(1'b1, 1'b1, 1'b1, 8'h00, 32'h0,         8'h00, 1'b0, 8'h00);
        vecs[3] = mk(1'b0, 1'b1, 1'b1, 8'h00, 32'h0,         8'h00, 1'b0, 8'h00);
        vecs[4] = mk(1'b1, 1'b1, 1'b1, 8'h31, 32'h0020_1001, 8'h00, 1'b0, 8'h31);
        vecs[5] = mk(1'b1, 1'b1, 1'b1, 8'h00, 32'h0,         8'h01, 1'b1, 8'h31);
        vecs[6] = mk(1'b1, 1'b1, 1'b1, 8'h00, 32'h0,         8'h10, 1'b1, 8'h30);
        vecs[7] = mk(1'b1, 1'b1, 1'b1, 8'h00, 32'h0,         8'h20, 1'b1, 8'h20);
        vecs[8] = mk(1'b1, 1'b1, 1'b1, 8'h00, 32'h0,         8'h00, 1'b0, 8'h00);

        rst_n = 1'b0;
        u_if.req = '0;
        u_if.en = 1'b0;
        u_if.grant_rdy = 1'b0;
        tick();
        tick();
        chk("rst_grant",   32'(u_if.grant),     32'h0);
        chk("rst_vld",     32'(u_if.grant_vld), 32'h0);
        chk("rst_pending", 32'(u_if.pending),   32'h0);
        chk("rst_ptr",     32'(dut.r_ptr),      32'h0);
`ifdef RR_OVF_FLAG_EN
        chk("rst_ovf",     32'(u_if.ovf),       32'h0);
`endif

        for (int i = 0; i < 9; i++) begin
            rst_n = vecs[i].rst_n;
            u_if.en = vecs[i].en;
            u_if.grant_rdy = vecs[i].rdy;
            u_if.req = vecs[i].req;
            for (int b = 0; b < 4; b++)
                if (vecs[i].sb[b*8 +: 8] != 8'h00) sb_q.push_back(vecs[i].sb[b*8 +: 8]);
            tick();
            chk($sformatf("vec%0d_grant", i), 32'(u_if.grant),     32'(vecs[i].exp_grant));
            chk($sformatf("vec%0d_vld", i),   32'(u_if.grant_vld), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_pend", i),  32'(u_if.pending),   32'(vecs[i].exp_pend));
            if (i == 2) chk("ptr_after_single", 32'(dut.r_ptr), 32'd3);
        end

        // Stall: grant held while ready is low, next pending bit follows without a bubble.
        do_reset();
        u_if.en = 1'b1;
        u_if.req = 8'h03;
        sb_q.push_back(8'h01);
        sb_q.push_back(8'h02);
        tick();
        u_if.req = 8'h00;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_grant", k), 32'(u_if.grant),     32'h01);
            chk($sformatf("stall%0d_vld", k),   32'(u_if.grant_vld), 32'h1);
            tick();
        end
        u_if.grant_rdy = 1'b1;
        tick();
        chk("stall_next_grant", 32'(u_if.grant),     32'h02);
        chk("stall_next_vld",   32'(u_if.grant_vld), 32'h1);
        tick();
        chk("stall_done_vld",   32'(u_if.grant_vld), 32'h0);

        // En low blocks grants; rotation from Ptr=6.
        do_reset();
        u_if.en = 1'b1;
        u_if.grant_rdy = 1'b1;
        u_if.req = 8'h20;
        sb_q.push_back(8'h20);
        tick();
        u_if.req = 8'h00;
        tick();
        tick();
        chk("ptr_six", 32'(dut.r_ptr), 32'd6);
        u_if.en = 1'b0;
        u_if.req = 8'hFF;
        tick();
        u_if.req = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("en0_vld%0d", k),  32'(u_if.grant_vld), 32'h0);
            chk($sformatf("en0_pend%0d", k), 32'(u_if.pending),   32'hFF);
        end
        for (int k = 0; k < 8; k++) begin
            ev = 8'h01 << ((6 + k) % 8);
            sb_q.push_back(ev);
        end
        u_if.en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            ev = 8'h01 << ((6 + k) % 8);
            chk($sformatf("rot%0d_grant", k), 32'(u_if.grant), 32'(ev));
        end
        tick();
        chk("rot_end_vld",  32'(u_if.grant_vld), 32'h0);
        chk("rot_end_pend", 32'(u_if.pending),   32'h0);

        // Duplicate requests on a pending bit merge into one grant.
        do_reset();
        u_if.en = 1'b1;
        u_if.req = 8'h04;
        sb_q.push_back(8'h04);
        tick();
        u_if.req = 8'h00;
        tick();
        u_if.req = 8'h04;
        tick();
        u_if.req = 8'h00;
        tick();
        u_if.req = 8'h04;
        tick();
        u_if.req = 8'h00;
        chk("dup_pend", 32'(u_if.pending), 32'h04);
`ifdef RR_OVF_FLAG_EN
        chk("dup_ovf_set", 32'(u_if.ovf), 32'h1);
`endif
        u_if.grant_rdy = 1'b1;
        tick();
        chk("dup_vld_after", 32'(u_if.grant_vld), 32'h0);
        chk("dup_pend_after", 32'(u_if.pending), 32'h00);
        tick();
        chk("dup_no_regrant", 32'(u_if.grant_vld), 32'h0);
`ifdef RR_OVF_FLAG_EN
        chk("dup_ovf_sticky", 32'(u_if.ovf), 32'h1);
`endif

        // Asynchronous reset in the middle of a handshake.
        do_reset();
        u_if.en = 1'b1;
        u_if.req = 8'h01;
        sb_q.push_back(8'h01);
        tick();
        u_if.req = 8'h00;
        tick();
        chk("arst_pre_vld", 32'(u_if.grant_vld), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",   32'(u_if.grant_vld), 32'h0);
        chk("arst_grant", 32'(u_if.grant),     32'h0);
        chk("arst_pend",  32'(u_if.pending),   32'h0);
`ifdef RR_OVF_FLAG_EN
        chk("arst_ovf",   32'(u_if.ovf),       32'h0);
`endif
        void'(sb_q.pop_back());
        tick();
        rst_n = 1'b1;
        tick();

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
